// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU slice: instruction classes, issuer
// states and the per-class hold lengths that match the control unit FSM.
package cpu_pkg;

    localparam int INSTR_WIDTH = 20;

    localparam logic [1:0] CLS_HALT  = 2'b00;
    localparam logic [1:0] CLS_STD   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    localparam int unsigned HOLD_STD   = 3;
    localparam int unsigned HOLD_LOAD  = 4;
    localparam int unsigned HOLD_STORE = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Edges the control unit spends on one word of the given class; HALT is never held.
    function automatic int unsigned hold_for_class(
        input logic [1:0]  cls,
        input int unsigned std_h   = HOLD_STD,
        input int unsigned load_h  = HOLD_LOAD,
        input int unsigned store_h = HOLD_STORE
    );
        case (cls)
            CLS_STD:   return std_h;
            CLS_LOAD:  return load_h;
            CLS_STORE: return store_h;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/instr_store.sv
// Program store: synchronous write, asynchronous read, contents survive reset.
module instr_store #(
    parameter int PROG_BITS   = 4,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   wen,
    input  logic [PROG_BITS-1:0]   waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [PROG_BITS-1:0]   raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);

    logic [INSTR_WIDTH-1:0] mem [2**PROG_BITS];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Presents program words to the CPU control unit, holding each one for exactly
// the number of edges the CU FSM needs for its class, then advancing.
module instr_issuer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PROG_BITS   = 4,
    parameter int HOLD_STD    = 3,
    parameter int HOLD_LOAD   = 4,
    parameter int HOLD_STORE  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_wen,
    input  logic [PROG_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PROG_BITS-1:0]   pc,
    output logic                   issue,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state_dbg
);

    import cpu_pkg::*;

    localparam int MAX_HOLD = (HOLD_LOAD > HOLD_STD)
                            ? ((HOLD_LOAD > HOLD_STORE) ? HOLD_LOAD : HOLD_STORE)
                            : ((HOLD_STD > HOLD_STORE) ? HOLD_STD : HOLD_STORE);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [PROG_BITS-1:0] LAST_ADDR = {PROG_BITS{1'b1}};

    state_t                 state, state_n;
    logic [INSTR_WIDTH-1:0] instr_n;
    logic [PROG_BITS-1:0]   pc_n;
    logic                   issue_n;
    logic [CNT_W-1:0]       cnt, cnt_n;

    logic [PROG_BITS-1:0]   rd_addr;
    logic [INSTR_WIDTH-1:0] rd_data;
    logic [1:0]             rd_cls;

    instr_store #(
        .PROG_BITS   (PROG_BITS),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_store (
        .clk   (clk),
        .wen   (prog_wen && (state == IDLE)),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // In IDLE the read port looks at word 0; while issuing it looks one word ahead.
    assign rd_addr = (state == ISSUE) ? pc + 1'b1 : '0;
    assign rd_cls  = rd_data[INSTR_WIDTH-1 -: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= '0;
            pc          <= '0;
            issue       <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            instruction <= instr_n;
            pc          <= pc_n;
            issue       <= issue_n;
            cnt         <= cnt_n;
        end
    end

    // cnt holds the remaining edges minus one; the word advances on the edge where it is zero.
    always_comb begin
        state_n = state;
        instr_n = instruction;
        pc_n    = pc;
        issue_n = 1'b0;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    pc_n = '0;
                    if (rd_cls == CLS_HALT) begin
                        state_n = DONE;
                        instr_n = '0;
                    end else begin
                        // First word gets one extra edge for the CU's RESET state.
                        state_n = ISSUE;
                        instr_n = rd_data;
                        issue_n = 1'b1;
                        cnt_n   = CNT_W'(hold_for_class(rd_cls, HOLD_STD, HOLD_LOAD, HOLD_STORE));
                    end
                end
            end
            ISSUE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (pc == LAST_ADDR) begin
                    state_n = DONE;
                    instr_n = '0;
                end else begin
                    pc_n = pc + 1'b1;
                    if (rd_cls == CLS_HALT) begin
                        state_n = DONE;
                        instr_n = '0;
                    end else begin
                        instr_n = rd_data;
                        issue_n = 1'b1;
                        cnt_n   = CNT_W'(hold_for_class(rd_cls, HOLD_STD, HOLD_LOAD, HOLD_STORE) - 1);
                    end
                end
            end
            DONE: begin
                instr_n = '0;
            end
            default: begin
                state_n = IDLE;
                instr_n = '0;
            end
        endcase
    end

    assign busy      = (state == ISSUE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: directed programs plus random ones, each expanded
// into a per-cycle trace from the hold rules and compared every cycle.
module tb_instr_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        prog_wen = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic [19:0] instruction;
    logic [3:0]  pc;
    logic        issue, busy, done;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    logic [19:0] mprog [16];
    logic [26:0] exp_q [$];

    instr_issuer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_wen    (prog_wen),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .pc          (pc),
        .issue       (issue),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] pk(logic [19:0] i, logic [3:0] p, logic is, logic b, logic d);
        return {i, p, is, b, d};
    endfunction

    function automatic int hold_of(logic [19:0] w);
        case (w[19:18])
            2'b01:   return 3;
            2'b10:   return 4;
            2'b11:   return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expand the program into the per-cycle view seen after start is taken.
    function automatic int build_expected(int tail);
        int n_issue = 0;
        int last_pc = 0;
        exp_q.delete();
        for (int a = 0; a < 16; a++) begin
            if (mprog[a][19:18] == 2'b00) begin
                last_pc = a;
                break;
            end
            for (int k = 0; k < hold_of(mprog[a]) + (a == 0 ? 1 : 0); k++)
                exp_q.push_back(pk(mprog[a], 4'(a), k == 0, 1'b1, 1'b0));
            n_issue++;
            last_pc = a;
        end
        for (int k = 0; k < tail; k++)
            exp_q.push_back(pk(20'h0, 4'(last_pc), 1'b0, 1'b0, 1'b1));
        return n_issue;
    endfunction

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("reset_outputs", {instruction, pc, issue, busy, done}, pk(20'h0, 4'h0, 0, 0, 0));
        check("reset_state", state_dbg, 2'd0);
    endtask

    task automatic load_prog();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            prog_wen  = 1'b1;
            prog_addr = 4'(a);
            prog_data = mprog[a];
        end
        @(negedge clk) prog_wen = 1'b0;
    endtask

    // limit < 0 checks the whole trace; otherwise stop after limit cycles and reset.
    task automatic run_prog(string tag, int limit, bit poke, bit wr_on_start, logic [19:0] wr_val);
        int n_exp, n_seen, cyc;
        logic [26:0] e;
        n_exp  = build_expected(3);
        n_seen = 0;
        cyc    = 0;
        @(negedge clk);
        start = 1'b1;
        if (wr_on_start) begin
            prog_wen  = 1'b1;
            prog_addr = 4'h0;
            prog_data = wr_val;
        end
        @(negedge clk);
        start    = 1'b0;
        prog_wen = 1'b0;
        if (wr_on_start) mprog[0] = wr_val;
        while (exp_q.size() > 0 && (limit < 0 || cyc < limit)) begin
            e = exp_q.pop_front();
            check($sformatf("%s_cyc%0d", tag, cyc + 1), {instruction, pc, issue, busy, done}, e);
            n_seen += issue;
            cyc++;
            if (poke) begin
                start     = 1'($urandom_range(0, 1));
                prog_wen  = 1'($urandom_range(0, 1));
                prog_addr = 4'h0;
                prog_data = 20'hE4030;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        prog_wen = 1'b0;
        if (limit < 0) begin
            check({tag, "_issue_count"}, n_seen, n_exp);
        end else begin
            rst = 1'b1;
            @(negedge clk) rst = 1'b0;
            check({tag, "_rst_outputs"}, {instruction, busy, done}, {20'h0, 1'b0, 1'b0});
            check({tag, "_rst_state"}, state_dbg, 2'd0);
        end
    endtask

    task automatic set_prog2();
        for (int a = 0; a < 16; a++) mprog[a] = 20'h0;
        mprog[0] = 20'h5B000;
        mprog[1] = 20'h84050;
        mprog[2] = 20'hE4030;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();

        // Single std word then HALT.
        for (int a = 0; a < 16; a++) mprog[a] = 20'h0;
        mprog[0] = 20'h5B000;
        load_prog();
        run_prog("one_word", -1, 0, 0, 20'h0);
        check("one_word_done_pc", {done, pc}, {1'b1, 4'h1});

        // std, loadR, storeR, HALT.
        do_reset();
        set_prog2();
        load_prog();
        run_prog("three_words", -1, 0, 0, 20'h0);

        // Full store, no HALT.
        do_reset();
        for (int a = 0; a < 16; a++) mprog[a] = 20'h5B000;
        load_prog();
        run_prog("full_store", -1, 0, 0, 20'h0);
        check("full_store_end", {done, pc}, {1'b1, 4'hF});

        // Reset two cycles into the second word, then the program reruns intact.
        do_reset();
        set_prog2();
        load_prog();
        run_prog("mid_rst", 6, 0, 0, 20'h0);
        run_prog("after_rst", -1, 0, 0, 20'h0);

        // start/prog_wen pokes during ISSUE and DONE must be ignored.
        do_reset();
        run_prog("poke", -1, 1, 0, 20'h0);
        do_reset();
        run_prog("post_poke", -1, 0, 0, 20'h0);

        // Write word 0 in the same cycle as start: old word goes out first.
        do_reset();
        run_prog("wr_start", -1, 0, 1, 20'h84050);
        do_reset();
        run_prog("wr_start_new", -1, 0, 0, 20'h0);

        // HALT at address 0.
        do_reset();
        mprog[0] = 20'h00000;
        load_prog();
        run_prog("halt_first", -1, 0, 0, 20'h0);

        // Random programs.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int a = 0; a < 16; a++) begin
                mprog[a] = 20'($urandom);
                if ($urandom_range(0, 7) == 0)
                    mprog[a][19:18] = 2'b00;
                else
                    mprog[a][19:18] = 2'($urandom_range(1, 3));
            end
            load_prog();
            run_prog($sformatf("rand%0d", r), -1, r[0], 0, 20'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
